// File: rtl/demux_pkg.sv
// Shared types and constants for the serial feeder of the 1-to-4 gate-level demux.
package demux_pkg;

    localparam int CHAN_W = 2;
    localparam int WCNT_W = 16;

    localparam logic [CHAN_W-1:0] CH_Z0 = 2'b00;
    localparam logic [CHAN_W-1:0] CH_Z1 = 2'b01;
    localparam logic [CHAN_W-1:0] CH_Z2 = 2'b10;
    localparam logic [CHAN_W-1:0] CH_Z3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/demux_piso_shreg.sv
// Parallel-load shift register with bit index counter; exposes the bit that follows
// the one currently on the line, plus a flag marking the last bit of the word.
module demux_piso_shreg #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_adv,
    output logic              o_next,
    output logic              o_last
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_idx   <= '0;
        end else if (i_adv) begin
            r_shift <= (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                        : {1'b0, r_shift[DATA_W-1:1]};
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Bit 0 of the word is driven by the top at load time, so this looks one ahead.
    assign o_next = (MSB_FIRST != 0) ? r_shift[DATA_W-2] : r_shift[1];
    assign o_last = (r_idx == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/demux_ser_driver.sv
// Serialises a parallel word onto the demux data line with stable select lines,
// followed by an optional idle gap and a completion pulse.
module demux_ser_driver
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHAN_W-1:0] in_chan,
    output logic              sel_a,
    output logic              sel_b,
    output logic              d,
    output logic              busy,
    output logic              done,
    output logic [WCNT_W-1:0] word_cnt
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t            r_state;
    logic              r_ready;
    logic              r_sel_a;
    logic              r_sel_b;
    logic              r_d;
    logic              r_busy;
    logic              r_done;
    logic [WCNT_W-1:0] r_wcnt;
    logic [3:0]        r_gap;

    logic w_accept;
    logic w_first;
    logic w_next;
    logic w_last;
    logic w_adv;

    assign w_accept = in_valid & r_ready;
    assign w_first  = (MSB_FIRST != 0) ? in_data[DATA_W-1] : in_data[0];
    assign w_adv    = (r_state == SHIFT) & ~w_last;

    demux_piso_shreg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_data (in_data),
        .i_adv  (w_adv),
        .o_next (w_next),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_sel_a <= 1'b0;
            r_sel_b <= 1'b0;
            r_d     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wcnt  <= '0;
            r_gap   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_d     <= 1'b0;
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_sel_a <= in_chan[1];
                        r_sel_b <= in_chan[0];
                        r_d     <= w_first;
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_d    <= 1'b0;
                        r_done <= 1'b1;
                        r_wcnt <= r_wcnt + 1'b1;
                        if (GAP_CYC > 0) begin
                            r_state <= GAP;
                            r_gap   <= GAP_LOAD;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_d <= w_next;
                    end
                end
                GAP: begin
                    // The done cycle is the first gap cycle, hence the load of GAP_CYC-1.
                    if (r_gap == 4'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_d     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_ready;
    assign sel_a    = r_sel_a;
    assign sel_b    = r_sel_b;
    assign d        = r_d;
    assign busy     = r_busy;
    assign done     = r_done;
    assign word_cnt = r_wcnt;

endmodule

// File: tb/tb_demux_ser_driver.sv
// Directed bench: unit A uses default parameters, unit B is LSB-first with no gap.
module tb_demux_ser_driver;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0]  a_data = '0, b_data = '0;
    logic [1:0]  a_chan = '0, b_chan = '0;
    logic        a_ready, a_sa, a_sb, a_d, a_busy, a_done;
    logic        b_ready, b_sa, b_sb, b_d, b_busy, b_done;
    logic [15:0] a_wcnt, b_wcnt;

    demux_ser_driver #(.DATA_W(8), .MSB_FIRST(1), .GAP_CYC(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_chan(a_chan), .sel_a(a_sa), .sel_b(a_sb),
        .d(a_d), .busy(a_busy), .done(a_done), .word_cnt(a_wcnt)
    );

    demux_ser_driver #(.DATA_W(8), .MSB_FIRST(0), .GAP_CYC(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_chan(b_chan), .sel_a(b_sa), .sel_b(b_sb),
        .d(b_d), .busy(b_busy), .done(b_done), .word_cnt(b_wcnt)
    );

    typedef struct {
        logic        ready, sa, sb, d, busy, done;
        logic [15:0] wcnt;
    } out_t;

    typedef struct {
        int         u;
        logic [7:0] data;
        logic [1:0] chan;
        logic [7:0] seq;     // expected d stream, first bit at [7]
        logic       sa, sb;
        bit         toggle;
    } rec_t;

    int total = 0;
    int bad   = 0;
    int exp_wcnt [2] = '{0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic out_t get(input int u);
        out_t o;
        if (u == 0) o = '{a_ready, a_sa, a_sb, a_d, a_busy, a_done, a_wcnt};
        else        o = '{b_ready, b_sa, b_sb, b_d, b_busy, b_done, b_wcnt};
        return o;
    endfunction

    task automatic drive(input int u, input logic v, input logic [7:0] dt, input logic [1:0] ch);
        if (u == 0) begin a_valid = v; a_data = dt; a_chan = ch; end
        else        begin b_valid = v; b_data = dt; b_chan = ch; end
    endtask

    task automatic wait_ready(input int u);
        out_t o;
        for (int i = 0; i < 32; i++) begin
            o = get(u);
            if (o.ready) break;
            @(negedge clk);
        end
        o = get(u);
        chk("ready_wait", 32'(o.ready), 32'd1);
    endtask

    task automatic run_word(input rec_t r);
        out_t o;
        wait_ready(r.u);
        drive(r.u, 1'b1, r.data, r.chan);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (r.toggle) drive(r.u, 1'b1, 8'($urandom), 2'($urandom));
            else          drive(r.u, 1'b0, 8'h00, 2'd0);
            o = get(r.u);
            chk("shift_d",     32'(o.d),     32'(r.seq[7-i]));
            chk("shift_sel",   {o.sa, o.sb}, {r.sa, r.sb});
            chk("shift_busy",  32'(o.busy),  32'd1);
            chk("shift_ready", 32'(o.ready), 32'd0);
            chk("shift_done",  32'(o.done),  32'd0);
        end
        @(negedge clk);
        drive(r.u, 1'b0, 8'h00, 2'd0);
        exp_wcnt[r.u]++;
        o = get(r.u);
        chk("done_pulse", 32'(o.done), 32'd1);
        chk("done_d",     32'(o.d),    32'd0);
        chk("done_wcnt",  32'(o.wcnt), 32'(exp_wcnt[r.u]));
        chk("done_busy",  32'(o.busy), (r.u == 0) ? 32'd1 : 32'd0);
        chk("done_ready", 32'(o.ready), (r.u == 0) ? 32'd0 : 32'd1);
        if (r.u == 0) begin
            @(negedge clk);
            o = get(0);
            chk("idle_ready", 32'(o.ready), 32'd1);
            chk("idle_busy",  32'(o.busy),  32'd0);
            chk("idle_done",  32'(o.done),  32'd0);
            chk("idle_d",     32'(o.d),     32'd0);
            chk("idle_sel",   {o.sa, o.sb}, {r.sa, r.sb});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rec_t  tbl [5];
        out_t  o;
        logic [17:0] a_seq;
        logic [16:0] b_seq;

        tbl[0] = '{0, 8'hA5, CH_Z2, 8'b10100101, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h3C, CH_Z0, 8'b00111100, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{0, 8'h96, CH_Z1, 8'b10010110, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1, 8'h01, CH_Z3, 8'b10000000, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1, 8'h1E, CH_Z0, 8'b01111000, 1'b0, 1'b0, 1'b1};

        // Reset held with valid asserted
        rst_n = 1'b0;
        drive(0, 1'b1, 8'hA5, CH_Z3);
        drive(1, 1'b1, 8'hA5, CH_Z3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                o = get(u);
                chk("rst_ready", 32'(o.ready), 32'd0);
                chk("rst_d",     32'(o.d),     32'd0);
                chk("rst_sel",   {o.sa, o.sb}, 32'd0);
                chk("rst_busy",  32'(o.busy),  32'd0);
                chk("rst_wcnt",  32'(o.wcnt),  32'd0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            o = get(u);
            chk("rel_ready", 32'(o.ready), 32'd1);
            chk("rel_busy",  32'(o.busy),  32'd0);
        end
        drive(0, 1'b0, 8'h00, 2'd0);
        drive(1, 1'b0, 8'h00, 2'd0);
        @(negedge clk);

        foreach (tbl[k]) run_word(tbl[k]);

        // Unit A: valid held high across two words, 10-cycle accept spacing
        a_seq = 18'b11111111_0_0_00001111;
        wait_ready(0);
        drive(0, 1'b1, 8'hFF, CH_Z1);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) drive(0, 1'b1, 8'h0F, CH_Z3);
            o = get(0);
            chk("hold_a_d",   32'(o.d),     32'(a_seq[17-c]));
            chk("hold_a_sel", {o.sa, o.sb}, (c < 10) ? 32'd1 : 32'd3);
            if (c == 8) begin
                chk("hold_a_done", 32'(o.done), 32'd1);
                chk("hold_a_wcnt", 32'(o.wcnt), 32'(exp_wcnt[0] + 1));
            end
            if (c == 9) chk("hold_a_ready", 32'(o.ready), 32'd1);
        end
        drive(0, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        exp_wcnt[0] += 2;
        o = get(0);
        chk("hold_a_done2", 32'(o.done), 32'd1);
        chk("hold_a_wcnt2", 32'(o.wcnt), 32'(exp_wcnt[0]));
        @(negedge clk);

        // Unit B: no gap, 9-cycle accept spacing
        b_seq = 17'b10000000_0_01111000;
        wait_ready(1);
        drive(1, 1'b1, 8'h01, CH_Z3);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (c == 0) drive(1, 1'b1, 8'h1E, CH_Z0);
            o = get(1);
            chk("hold_b_d",   32'(o.d),     32'(b_seq[16-c]));
            chk("hold_b_sel", {o.sa, o.sb}, (c < 9) ? 32'd3 : 32'd0);
            if (c == 8) begin
                chk("hold_b_done",  32'(o.done),  32'd1);
                chk("hold_b_ready", 32'(o.ready), 32'd1);
            end
        end
        drive(1, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        exp_wcnt[1] += 2;
        o = get(1);
        chk("hold_b_done2", 32'(o.done), 32'd1);
        chk("hold_b_wcnt2", 32'(o.wcnt), 32'(exp_wcnt[1]));
        @(negedge clk);

        // Unit A: reset during bit 4 of 8'hC3
        wait_ready(0);
        drive(0, 1'b1, 8'hC3, CH_Z1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 1'b0, 8'h00, 2'd0);
            o = get(0);
            chk("mid_d", 32'(o.d), (i < 2) ? 32'd1 : 32'd0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        o = get(0);
        chk("mid_rst_d",     32'(o.d),     32'd0);
        chk("mid_rst_busy",  32'(o.busy),  32'd0);
        chk("mid_rst_done",  32'(o.done),  32'd0);
        chk("mid_rst_wcnt",  32'(o.wcnt),  32'd0);
        chk("mid_rst_ready", 32'(o.ready), 32'd0);
        chk("mid_rst_sel",   {o.sa, o.sb}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        o = get(0);
        chk("mid_rel_ready", 32'(o.ready), 32'd1);
        chk("mid_rel_done",  32'(o.done),  32'd0);
        chk("mid_rel_busy",  32'(o.busy),  32'd0);
        chk("mid_rel_wcnt",  32'(o.wcnt),  32'd0);
        o = get(1);
        chk("mid_b_wcnt",    32'(o.wcnt),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_ser_driver.md
Name: demux_ser_driver

Overview:
- Upstream feeder for the 4-way 1-to-4 gate-level demux (select a/b, data d, outputs z0..z3).
- Accepts a parallel word plus a 2-bit destination channel over a valid/ready handshake.
- Serialises the word bit-by-bit onto d, holding the select lines stable, so the demux steers the bit stream to one channel.
- Inserts a configurable idle gap (d=0) between words and reports completion.

Parameters:
- DATA_W, 8: bits per word; range 2..32.
- MSB_FIRST, 1: 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- GAP_CYC, 1: idle cycles with d=0 after each word; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream word available.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  word to serialise.
- in_chan  in  2  destination channel 0..3.
- sel_a  out  1  demux select MSB (in_chan[1]).
- sel_b  out  1  demux select LSB (in_chan[0]).
- d  out  1  serial data to demux.
- busy  out  1  high in SHIFT and GAP.
- done  out  1  one-cycle pulse after the last bit of a word.
- word_cnt  out  16  count of completed words.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: state=IDLE, in_ready=0, sel_a=0, sel_b=0, d=0, busy=0, done=0, word_cnt=0.
- in_ready rises at the first edge with rst_n=1. Thereafter in_ready=1 exactly while in IDLE.
- Accept: in_valid & in_ready at an edge. At that edge:
  - latch in_data and in_chan;
  - sel_a<=in_chan[1], sel_b<=in_chan[0];
  - d<=first bit; state<=SHIFT; busy<=1; in_ready<=0.
- Latency: first bit on d in the cycle right after the accept edge.
- SHIFT: d carries bit i in cycle i (i = 0..DATA_W-1), in the order set by MSB_FIRST. Bit index is a counter 0..DATA_W-1. sel_a/sel_b are held constant for the whole word.
- End of word: at the edge after bit DATA_W-1:
  - d<=0; done<=1 for exactly one cycle; word_cnt<=word_cnt+1 (wraps 0xFFFF->0x0000).
  - If GAP_CYC>0: state<=GAP, busy stays 1. Else: state<=IDLE, busy<=0, in_ready<=1.
- GAP: d=0 for GAP_CYC cycles, counted from the done cycle. Then state<=IDLE, busy<=0, in_ready<=1.
- Word spacing: minimum accept-to-accept spacing is DATA_W+GAP_CYC+1 cycles (GAP_CYC=0 still costs one cycle in IDLE).
- IDLE: d=0 (all demux outputs low). sel_a/sel_b keep the last value (no toggling).
- in_valid while not ready: ignored. in_data/in_chan may change freely and have no effect on the word in flight.
- Invariant: d is 0 whenever busy=0, and sel never changes while d could be 1.
- Reset mid-word (rst_n=0 in SHIFT or GAP): at that edge all registers take reset values. No done pulse. The partial word is discarded.
- States: IDLE -> SHIFT (accept); SHIFT -> GAP or IDLE (last bit); GAP -> IDLE (gap count expires). Any state -> IDLE on reset.

Decomposition:
- Shared package demux_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - CHAN_W=2;
  - channel constants CH_Z0=2'b00, CH_Z1=2'b01, CH_Z2=2'b10, CH_Z3=2'b11;
  - WCNT_W=16.
- One sub-module, demux_piso_shreg: parallel-load shift register with bit counter and last-bit flag, parameterised by DATA_W and MSB_FIRST.
- The top holds the FSM, gap counter, select registers and word counter.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, d=0, sel_a=0, sel_b=0, busy=0, word_cnt=0, nothing accepted. in_ready=1 one edge after release.
- Defaults, in_data=8'hA5, in_chan=2 -> sel_a=1, sel_b=0 for 8 cycles; d=1,0,1,0,0,1,0,1; done pulses once in the 9th cycle; word_cnt=1.
- in_valid held high with two words (8'hFF to ch1, 8'h0F to ch3) -> accepts 10 cycles apart. Gap cycle has d=0. sel changes 1->3 only at the second accept. word_cnt=2.
- During SHIFT, toggle in_data/in_chan every cycle with in_valid=1 -> in_ready stays 0, serial stream unchanged, no extra accept.
- rst_n=0 for one cycle at bit 4 of 8'hC3 -> d=0 and busy=0 next cycle, no done pulse, word_cnt=0, in_ready=1 one cycle later.
- MSB_FIRST=0, GAP_CYC=0, in_data=8'h01, in_chan=3 -> sel_a=sel_b=1; d=1 then seven 0s; in_ready=1 in the cycle after the done edge; next accept possible 9 cycles after the first.
